// File: rtl/axi_pkg.sv
// Shared response codes and FSM state encodings for the AXI slave memory responder.
// Pure declarations; no timing or handshake behaviour lives here.
// Imported by the top level.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    function automatic logic [1:0] resp_for(input logic in_range);
        return in_range ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi_mem_bytewr.sv
// DEPTH x DATA_W storage with a byte-strobed synchronous write port and a combinational read port.
// Write lands on the clock edge; read data follows raddr in the same cycle.
// No backpressure: a write is taken whenever we is high.
module axi_mem_bytewr #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; only strobed lanes are overwritten.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_slave_mem_responder.sv
// AXI4-style slave memory: AW/W/B write path with byte strobes, AR/R read bursts of BLEN+1 beats.
// Write costs AW, W, B cycles; first read beat is valid one cycle after the AR handshake, then one beat per cycle.
// RVALID/BVALID hold with stable payload until the matching READY; AWREADY/ARREADY drop while a transaction is open.
module axi_slave_mem_responder
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int BLEN_W = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_W-1:0]     ARADDR,
    input  logic [BLEN_W-1:0]     BLEN,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_W-1:0]     RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY
);

    localparam int              MW    = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

    w_state_e          w_state;
    logic [ADDR_W-1:0] waddr_q;
    logic              w_in_range;
    logic              mem_we;

    r_state_e          r_state;
    logic [ADDR_W-1:0] raddr_q;
    logic [BLEN_W-1:0] cnt_q;
    logic [ADDR_W-1:0] ld_addr;
    logic [BLEN_W-1:0] ld_cnt;
    logic              ld_in_range;
    logic              ld_beat;
    logic [DATA_W-1:0] mem_rdata;

    assign w_in_range = (waddr_q < LIMIT);
    assign mem_we     = !ARESET && (w_state == W_DATA) && WVALID && WREADY && w_in_range;

    // The beat being loaded is either the first (RVALID still low) or the one after the beat just accepted.
    always_comb begin
        ld_addr     = raddr_q;
        ld_cnt      = cnt_q;
        if (RVALID) begin
            ld_addr = raddr_q + ADDR_W'(1);
            ld_cnt  = cnt_q - BLEN_W'(1);
        end
        ld_in_range = (ld_addr < LIMIT);
        ld_beat     = (r_state == R_DATA) && (!RVALID || (RREADY && !RLAST));
    end

    axi_mem_bytewr #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (MW)
    ) u_mem (
        .clk   (ACLK),
        .we    (mem_we),
        .waddr (waddr_q[MW-1:0]),
        .wdata (WDATA),
        .wstrb (WSTRB),
        .raddr (ld_addr[MW-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            waddr_q <= '0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (AWVALID && AWREADY) begin
                        waddr_q <= AWADDR;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (WVALID && WREADY) begin
                        WREADY  <= 1'b0;
                        BVALID  <= 1'b1;
                        BRESP   <= resp_for(w_in_range);
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                    AWREADY <= 1'b1;
                    WREADY  <= 1'b0;
                    BVALID  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            raddr_q <= '0;
            cnt_q   <= '0;
            ARREADY <= 1'b1;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ARVALID && ARREADY) begin
                        raddr_q <= ARADDR;
                        cnt_q   <= BLEN;
                        ARREADY <= 1'b0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (ld_beat) begin
                        raddr_q <= ld_addr;
                        cnt_q   <= ld_cnt;
                        RVALID  <= 1'b1;
                        RLAST   <= (ld_cnt == '0);
                        RDATA   <= ld_in_range ? mem_rdata : '0;
                        RRESP   <= resp_for(ld_in_range);
                    end else if (RREADY) begin
                        // Only reachable with RVALID && RLAST: the final beat was taken.
                        RVALID  <= 1'b0;
                        RLAST   <= 1'b0;
                        ARREADY <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                    ARREADY <= 1'b1;
                    RVALID  <= 1'b0;
                    RLAST   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Scoreboard bench for axi_slave_mem_responder: directed scenarios plus randomized writes/reads
// checked against a word-array reference model.
module tb_axi_slave_mem_responder;

    localparam int DEPTH = 64;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic [3:0]  BLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    axi_slave_mem_responder #(
        .ADDR_W (32), .DATA_W (32), .DEPTH (DEPTH), .BLEN_W (4)
    ) dut (
        .ACLK (ACLK), .ARESET (ARESET),
        .AWADDR (AWADDR), .AWVALID (AWVALID), .AWREADY (AWREADY),
        .WDATA (WDATA), .WSTRB (WSTRB), .WVALID (WVALID), .WREADY (WREADY),
        .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
        .ARADDR (ARADDR), .BLEN (BLEN), .ARVALID (ARVALID), .ARREADY (ARREADY),
        .RDATA (RDATA), .RRESP (RRESP), .RLAST (RLAST), .RVALID (RVALID), .RREADY (RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t      rq[$];
    logic [1:0]  bq[$];
    logic [31:0] mem_m [DEPTH];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          rmode   = 0;   // 0: ready held high, 1: random, 2: pattern 1,0,0

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting at %0t", nm, $time);
    endtask

    // Ready drivers for the response channels.
    int pat = 0;
    always @(posedge ACLK) begin
        #1;
        case (rmode)
            0:       begin RREADY = 1'b1; BREADY = 1'b1; end
            1:       begin RREADY = 1'($urandom_range(0, 1)); BREADY = 1'($urandom_range(0, 1)); end
            default: begin RREADY = (pat % 3 == 0); BREADY = (pat % 2 == 0); end
        endcase
        pat++;
    end

    // Monitor: every presented beat is compared with the scoreboard head, popped on handshake.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (RVALID) begin
                chk("ar_busy", 64'(ARREADY), 64'd0);
                if (rq.size() == 0) begin
                    chk("stray_r", 64'(RVALID), 64'd0);
                end else begin
                    chk("r_beat", {29'd0, RDATA, RRESP, RLAST},
                        {29'd0, rq[0].data, rq[0].resp, rq[0].last});
                    if (RREADY) void'(rq.pop_front());
                end
            end
            if (BVALID) begin
                chk("aw_busy", 64'(AWREADY), 64'd0);
                if (bq.size() == 0) begin
                    chk("stray_b", 64'(BVALID), 64'd0);
                end else begin
                    chk("b_resp", 64'(BRESP), 64'(bq[0]));
                    if (BREADY) void'(bq.pop_front());
                end
            end
        end
    end

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = '0;
        for (int k = 0; k < 4; k++) if (s[k]) mask[8*k +: 8] = 8'hFF;
        if (a < DEPTH) mem_m[a] = (mem_m[a] & ~mask) | (d & mask);
    endfunction

    task automatic wait_drain();
        int t = 0;
        while ((rq.size() != 0 || bq.size() != 0) && t < 400) begin
            @(posedge ACLK);
            t++;
        end
        if (rq.size() != 0 || bq.size() != 0) begin
            timeout("drain");
            rq.delete();
            bq.delete();
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_awready();
        int t = 0;
        @(negedge ACLK);
        while (!AWREADY && t < 100) begin @(negedge ACLK); t++; end
        if (!AWREADY) timeout("awready");
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit together);
        int t = 0;
        bq.push_back((a < DEPTH) ? 2'b00 : 2'b10);
        model_write(a, d, s);
        AWADDR = a; AWVALID = 1'b1;
        if (together) begin WDATA = d; WSTRB = s; WVALID = 1'b1; end
        wait_awready();
        if (together) chk("w_before_aw", 64'(WREADY), 64'd0);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WDATA = d; WSTRB = s; WVALID = 1'b1;
        @(negedge ACLK);
        while (!WREADY && t < 100) begin @(negedge ACLK); t++; end
        if (!WREADY) timeout("wready");
        @(posedge ACLK); #1;
        WVALID = 1'b0;
        wait_drain();
    endtask

    task automatic issue_read(input logic [31:0] a, input logic [3:0] blen);
        int t = 0;
        for (int i = 0; i <= int'(blen); i++) begin
            rbeat_t      b;
            logic [31:0] ba;
            ba     = a + 32'(i);
            b.data = (ba < DEPTH) ? mem_m[ba] : 32'd0;
            b.resp = (ba < DEPTH) ? 2'b00 : 2'b10;
            b.last = (i == int'(blen));
            rq.push_back(b);
        end
        ARADDR = a; BLEN = blen; ARVALID = 1'b1;
        @(negedge ACLK);
        while (!ARREADY && t < 100) begin @(negedge ACLK); t++; end
        if (!ARREADY) timeout("arready");
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] blen);
        issue_read(a, blen);
        wait_drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_awready"}, 64'(AWREADY), 64'd1);
        chk({tag, "_arready"}, 64'(ARREADY), 64'd1);
        chk({tag, "_wready"},  64'(WREADY),  64'd0);
        chk({tag, "_bvalid"},  64'(BVALID),  64'd0);
        chk({tag, "_rvalid"},  64'(RVALID),  64'd0);
        chk({tag, "_rlast"},   64'(RLAST),   64'd0);
    endtask

    task automatic pulse_reset();
        ARESET = 1'b1; AWVALID = 1'b0; ARVALID = 1'b0;
        @(posedge ACLK); #1;
        ARESET = 1'b0; WVALID = 1'b0;
        rq.delete();
        bq.delete();
        check_reset_outputs("rst_mid");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ARESET = 1'b1;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        ARADDR = '0; BLEN = '0; ARVALID = 1'b0;
        RREADY = 1'b1; BREADY = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        repeat (3) @(posedge ACLK);
        #1;
        check_reset_outputs("rst");
        chk("rst_bresp", 64'(BRESP), 64'd0);
        chk("rst_rresp", 64'(RRESP), 64'd0);
        chk("rst_rdata", 64'(RDATA), 64'd0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;

        // Preload the whole memory with zero through the bus.
        for (int i = 0; i < DEPTH; i++) do_write(32'(i), 32'd0, 4'hF, 1'b0);

        // Directed scenarios.
        do_write(32'd0, 32'h12345678, 4'b0001, 1'b0);
        do_read(32'd0, 4'd0);
        do_write(32'd1, 32'h87654321, 4'b0011, 1'b1);
        do_write(32'd1, 32'h45758264, 4'b0111, 1'b0);
        do_read(32'd1, 4'd0);
        do_write(32'd10, 32'h12345678, 4'b1111, 1'b0);
        rmode = 0;
        do_read(32'd0, 4'd3);
        rmode = 2; pat = 0;
        do_read(32'd2, 4'd15);
        rmode = 0;
        do_write(32'(DEPTH), 32'hDEADBEEF, 4'b1111, 1'b0);
        do_write(32'd5, 32'hCAFEF00D, 4'b0000, 1'b0);
        do_read(32'(DEPTH - 2), 4'd3);
        do_read(32'hFFFF_FFFE, 4'd3);

        // Reset mid-burst, after two of four beats.
        rmode = 0;
        do_write(32'd20, 32'hA5A5A5A5, 4'hF, 1'b0);
        issue_read(32'd18, 4'd3);
        begin
            int t = 0;
            while (rq.size() > 2 && t < 100) begin @(negedge ACLK); t++; end
            if (rq.size() > 2) timeout("mid_burst");
        end
        @(posedge ACLK); #1;
        pulse_reset();
        repeat (20) @(posedge ACLK);
        #1;

        // Reset on the cycle after AW is accepted: the pending write must not land.
        AWADDR = 32'd20; AWVALID = 1'b1;
        wait_awready();
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WDATA = 32'h0BADF00D; WSTRB = 4'hF; WVALID = 1'b1;
        pulse_reset();
        repeat (20) @(posedge ACLK);
        #1;
        do_read(32'd18, 4'd3);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            rmode = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 0) begin
                logic [31:0] a;
                case ($urandom_range(0, 5))
                    0:       a = 32'(DEPTH) + 32'($urandom_range(0, 3));
                    1:       a = $urandom;
                    default: a = 32'($urandom_range(0, DEPTH - 1));
                endcase
                do_write(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end else begin
                do_read(32'($urandom_range(0, DEPTH + 3)), 4'($urandom_range(0, 15)));
            end
        end

        rmode = 0;
        repeat (10) @(posedge ACLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
